pw_tile_sched: RTL and testbench
================================

PW_TILE_SCHED -- requirements
Module: pw_tile_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning buffer address width.
REQ-002 SHALL have parameter DIM_W, default 16, meaning dimension/counter width.
REQ-003 SHALL have parameter OC_PAR, default 8, meaning output channels per reader pass.
REQ-004 SHALL have port clk, input, 1, meaning clock.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, meaning layer start pulse.
REQ-007 SHALL have ports cfg_fm_h, cfg_fm_w, cfg_tile_h, cfg_tile_w, cfg_in_ch, cfg_out_ch, input, DIM_W each, meaning layer geometry.
REQ-008 SHALL have ports cfg_buf_base0 and cfg_buf_base1, input, ADDR_W each, meaning input-buffer base addresses.
REQ-009 SHALL have ports load_req (output, 1), load_row and load_col (output, DIM_W), load_h and load_w (output, DIM_W), load_base (output, ADDR_W) and load_ack (input, 1), meaning tile-fill request to the loader.
REQ-010 SHALL have ports rd_start (output, 1), rd_tile_h, rd_tile_w, rd_channels (output, DIM_W), rd_base_addr (output, ADDR_W) and rd_done (input, 1), meaning pointwise tile reader control.
REQ-011 SHALL have ports oc_group (output, DIM_W), wb_done (input, 1), busy (output, 1) and done (output, 1), meaning output-channel group, writeback acknowledge, activity flag and completion pulse.

Function
REQ-012 SHALL clock the states IDLE, LOAD, ISSUE, RUN, ADVANCE and FINISH.
REQ-013 SHALL, in IDLE on start, latch all cfg_* inputs, clear the tile and group counters, and enter LOAD.
REQ-014 SHALL ignore start in every state other than IDLE.
REQ-015 SHALL, when any latched dimension is zero, go directly to FINISH without issuing load_req or rd_start.
REQ-016 SHALL hold load_req high in LOAD until load_ack is seen, then enter ISSUE; load_* outputs SHALL be stable while load_req is high.
REQ-017 SHALL compute tile height as min(cfg_tile_h, fm_h - row) and tile width as min(cfg_tile_w, fm_w - col), so edge tiles are truncated.
REQ-018 SHALL drive rd_start as a one-cycle pulse in ISSUE with rd_tile_h/w = tile size, rd_channels = cfg_in_ch, rd_base_addr = active buffer base; rd_* SHALL be held until the next ISSUE.
REQ-019 SHALL, in RUN, latch rd_done and wb_done independently and leave RUN only once both are latched, in either order or in the same cycle.
REQ-020 SHALL, in ADVANCE, increment oc_group and return to ISSUE while oc_group+1 < ceil(cfg_out_ch/OC_PAR); otherwise it SHALL reset oc_group and step col by cfg_tile_w.
REQ-021 SHALL step to col 0 and row + cfg_tile_h when the column wraps, and enter LOAD for the next tile, or FINISH after the last tile.
REQ-022 SHALL pulse done for one cycle in FINISH and then return to IDLE.
REQ-023 SHALL hold busy high in every state except IDLE.
REQ-024 SHALL compute ceil-division and address arithmetic at DIM_W+1 bits so that no overflow occurs at the maximum dimension.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-layer, force IDLE, drive all outputs to 0, and clear the latched done flags.

Configuration
REQ-026 SHALL, with PW_SCHED_PINGPONG_EN defined, alternate the active buffer between base0 and base1 per tile and issue load_req for tile n+1 (into the idle buffer) during RUN of tile n, waiting on load_ack before ISSUE of n+1.
REQ-027 SHALL, without PW_SCHED_PINGPONG_EN, use only cfg_buf_base0 and issue load_req only in LOAD, after the previous tile has fully completed.

Structure
REQ-028 SHALL place the state enum, a ceil_div function and a tile-size min function in package pw_sched_pkg.
REQ-029 SHALL use one sub-module, pw_sched_tile_iter, holding the row/col counters, edge truncation and last-tile flag.

Verification
REQ-030 SHALL cover: fm 8x8, tile 4x4, in_ch 16, out_ch 16, OC_PAR 8 -> 4 loads, 8 rd_start pulses, done once.
REQ-031 SHALL cover: fm 10x6, tile 4x4 -> tile sizes 4x4, 4x2, 4x4, 4x2, 2x4, 2x2 in row-major order.
REQ-032 SHALL cover: out_ch 20, OC_PAR 8 -> oc_group sequence 0, 1, 2 per tile.
REQ-033 SHALL cover: wb_done arriving 5 cycles before rd_done, and the two arriving in the same cycle -> exactly one ADVANCE in each case.
REQ-034 SHALL cover: rst_n asserted during RUN -> all outputs 0 next cycle, and a fresh start runs a layer to completion.
REQ-035 SHALL cover: PW_SCHED_PINGPONG_EN defined, 2 tiles -> second load_req is high during first RUN with load_base = base1, and the second tile is issued with rd_base_addr = base1.

Source files
------------

// File: rtl/pw_sched_pkg.sv
// Shared types and arithmetic helpers for the pointwise tile scheduler.
// Optional ping-pong buffering is enabled with PW_SCHED_PINGPONG_EN.
package pw_sched_pkg;

  // Wide enough for DIM_W+1 / ADDR_W arithmetic without overflow.
  localparam int CALC_W = 40;

  typedef logic [CALC_W-1:0] calc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_RUN,
    S_ADVANCE,
    S_FINISH
  } state_t;

  function automatic calc_t ceil_div(input calc_t n, input calc_t d);
    if (d == '0) return '0;
    return (n + d - calc_t'(1)) / d;
  endfunction

  function automatic calc_t tile_min(input calc_t a, input calc_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/pw_sched_tile_iter.sv
// Row-major tile walker: row/col counters, edge-truncated tile size,
// next-tile lookahead and last-tile flag.
module pw_sched_tile_iter
  import pw_sched_pkg::*;
#(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  input  logic [DIM_W-1:0] fm_h,
  input  logic [DIM_W-1:0] fm_w,
  input  logic [DIM_W-1:0] tile_h,
  input  logic [DIM_W-1:0] tile_w,
  output logic [DIM_W-1:0] th,
  output logic [DIM_W-1:0] tw,
  output logic [DIM_W-1:0] nxt_row,
  output logic [DIM_W-1:0] nxt_col,
  output logic [DIM_W-1:0] nxt_h,
  output logic [DIM_W-1:0] nxt_w,
  output logic             last
);

  function automatic calc_t ext(input logic [DIM_W-1:0] v);
    return {{(CALC_W-DIM_W){1'b0}}, v};
  endfunction

  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] col;
  calc_t            row_end;
  calc_t            col_end;
  calc_t            nr;
  calc_t            nc;
  logic             wrap;

  always_comb begin
    row_end = ext(row) + ext(tile_h);
    col_end = ext(col) + ext(tile_w);
    wrap    = col_end >= ext(fm_w);
    last    = wrap && (row_end >= ext(fm_h));
    nr      = wrap ? row_end : ext(row);
    nc      = wrap ? '0 : col_end;
    th      = DIM_W'(tile_min(ext(tile_h), ext(fm_h) - ext(row)));
    tw      = DIM_W'(tile_min(ext(tile_w), ext(fm_w) - ext(col)));
    nxt_row = DIM_W'(nr);
    nxt_col = DIM_W'(nc);
    // Lookahead size is meaningless once last is set; consumers ignore it.
    nxt_h   = DIM_W'(tile_min(ext(tile_h), ext(fm_h) - nr));
    nxt_w   = DIM_W'(tile_min(ext(tile_w), ext(fm_w) - nc));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      row <= nxt_row;
      col <= nxt_col;
    end
  end

endmodule

// File: rtl/pw_tile_sched.sv
// Pointwise-conv tile scheduler: walks tiles, fills buffers, issues reader
// passes per output-channel group. Ping-pong fill with PW_SCHED_PINGPONG_EN.
module pw_tile_sched
  import pw_sched_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16,
  parameter int OC_PAR = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_fm_h,
  input  logic [DIM_W-1:0]  cfg_fm_w,
  input  logic [DIM_W-1:0]  cfg_tile_h,
  input  logic [DIM_W-1:0]  cfg_tile_w,
  input  logic [DIM_W-1:0]  cfg_in_ch,
  input  logic [DIM_W-1:0]  cfg_out_ch,
  input  logic [ADDR_W-1:0] cfg_buf_base0,
  input  logic [ADDR_W-1:0] cfg_buf_base1,
  output logic              load_req,
  output logic [DIM_W-1:0]  load_row,
  output logic [DIM_W-1:0]  load_col,
  output logic [DIM_W-1:0]  load_h,
  output logic [DIM_W-1:0]  load_w,
  output logic [ADDR_W-1:0] load_base,
  input  logic              load_ack,
  output logic              rd_start,
  output logic [DIM_W-1:0]  rd_tile_h,
  output logic [DIM_W-1:0]  rd_tile_w,
  output logic [DIM_W-1:0]  rd_channels,
  output logic [ADDR_W-1:0] rd_base_addr,
  input  logic              rd_done,
  output logic [DIM_W-1:0]  oc_group,
  input  logic              wb_done,
  output logic              busy,
  output logic              done
);

  function automatic calc_t ext(input logic [DIM_W-1:0] v);
    return {{(CALC_W-DIM_W){1'b0}}, v};
  endfunction

  state_t            state;
  logic [DIM_W-1:0]  fm_h_q;
  logic [DIM_W-1:0]  fm_w_q;
  logic [DIM_W-1:0]  tile_h_q;
  logic [DIM_W-1:0]  tile_w_q;
  logic [DIM_W-1:0]  in_ch_q;
  logic [DIM_W-1:0]  out_ch_q;
  logic [ADDR_W-1:0] base0_q;
  logic              got_rd;
  logic              got_wb;

  logic [DIM_W-1:0]  it_th;
  logic [DIM_W-1:0]  it_tw;
  logic [DIM_W-1:0]  it_nrow;
  logic [DIM_W-1:0]  it_ncol;
  logic [DIM_W-1:0]  it_nh;
  logic [DIM_W-1:0]  it_nw;
  logic              it_last;

  calc_t             grp_cnt;
  logic              grp_more;
  logic              tile_done;
  logic              it_clear;
  logic              it_step;
  logic              zero_cfg;
  logic              ack_now;
  logic [DIM_W-1:0]  first_h;
  logic [DIM_W-1:0]  first_w;
  logic [ADDR_W-1:0] active_base;

`ifdef PW_SCHED_PINGPONG_EN
  logic [ADDR_W-1:0] base1_q;
  logic              buf_sel;
  logic              pf_issued;
  logic              pf_acked;
  logic [ADDR_W-1:0] idle_base;

  assign active_base = buf_sel ? base1_q : base0_q;
  assign idle_base   = buf_sel ? base0_q : base1_q;
`else
  logic              unused_base1;

  assign active_base  = base0_q;
  assign unused_base1 = ^cfg_buf_base1;
`endif

  always_comb begin
    grp_cnt   = ceil_div(ext(out_ch_q), calc_t'(OC_PAR));
    grp_more  = (ext(oc_group) + calc_t'(1)) < grp_cnt;
    tile_done = (state == S_ADVANCE) && !grp_more;
    it_clear  = (state == S_IDLE) && start;
    it_step   = tile_done && !it_last;
    ack_now   = load_req && load_ack;
    zero_cfg  = (cfg_fm_h == '0) || (cfg_fm_w == '0) ||
                (cfg_tile_h == '0) || (cfg_tile_w == '0) ||
                (cfg_in_ch == '0) || (cfg_out_ch == '0);
    first_h   = DIM_W'(tile_min(ext(cfg_tile_h), ext(cfg_fm_h)));
    first_w   = DIM_W'(tile_min(ext(cfg_tile_w), ext(cfg_fm_w)));
  end

  pw_sched_tile_iter #(
    .DIM_W (DIM_W)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (it_clear),
    .step    (it_step),
    .fm_h    (fm_h_q),
    .fm_w    (fm_w_q),
    .tile_h  (tile_h_q),
    .tile_w  (tile_w_q),
    .th      (it_th),
    .tw      (it_tw),
    .nxt_row (it_nrow),
    .nxt_col (it_ncol),
    .nxt_h   (it_nh),
    .nxt_w   (it_nw),
    .last    (it_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      fm_h_q       <= '0;
      fm_w_q       <= '0;
      tile_h_q     <= '0;
      tile_w_q     <= '0;
      in_ch_q      <= '0;
      out_ch_q     <= '0;
      base0_q      <= '0;
      got_rd       <= 1'b0;
      got_wb       <= 1'b0;
      load_req     <= 1'b0;
      load_row     <= '0;
      load_col     <= '0;
      load_h       <= '0;
      load_w       <= '0;
      load_base    <= '0;
      rd_start     <= 1'b0;
      rd_tile_h    <= '0;
      rd_tile_w    <= '0;
      rd_channels  <= '0;
      rd_base_addr <= '0;
      oc_group     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef PW_SCHED_PINGPONG_EN
      base1_q      <= '0;
      buf_sel      <= 1'b0;
      pf_issued    <= 1'b0;
      pf_acked     <= 1'b0;
`endif
    end else begin
      rd_start <= 1'b0;
      done     <= 1'b0;
      if (ack_now) begin
        load_req <= 1'b0;
`ifdef PW_SCHED_PINGPONG_EN
        pf_acked <= 1'b1;
`endif
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            fm_h_q   <= cfg_fm_h;
            fm_w_q   <= cfg_fm_w;
            tile_h_q <= cfg_tile_h;
            tile_w_q <= cfg_tile_w;
            in_ch_q  <= cfg_in_ch;
            out_ch_q <= cfg_out_ch;
            base0_q  <= cfg_buf_base0;
            oc_group <= '0;
            busy     <= 1'b1;
`ifdef PW_SCHED_PINGPONG_EN
            base1_q   <= cfg_buf_base1;
            buf_sel   <= 1'b0;
            pf_issued <= 1'b0;
            pf_acked  <= 1'b0;
`endif
            if (zero_cfg) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state     <= S_LOAD;
              load_req  <= 1'b1;
              load_row  <= '0;
              load_col  <= '0;
              load_h    <= first_h;
              load_w    <= first_w;
              load_base <= cfg_buf_base0;
            end
          end
        end
        S_LOAD: begin
          if (ack_now) begin
            state <= S_ISSUE;
`ifdef PW_SCHED_PINGPONG_EN
            pf_acked <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          rd_start     <= 1'b1;
          rd_tile_h    <= it_th;
          rd_tile_w    <= it_tw;
          rd_channels  <= in_ch_q;
          rd_base_addr <= active_base;
          got_rd       <= 1'b0;
          got_wb       <= 1'b0;
          state        <= S_RUN;
`ifdef PW_SCHED_PINGPONG_EN
          // Prefetch the next tile into the idle buffer once per tile.
          if (!pf_issued && !it_last) begin
            pf_issued <= 1'b1;
            load_req  <= 1'b1;
            load_row  <= it_nrow;
            load_col  <= it_ncol;
            load_h    <= it_nh;
            load_w    <= it_nw;
            load_base <= idle_base;
          end
`endif
        end
        S_RUN: begin
          got_rd <= got_rd | rd_done;
          got_wb <= got_wb | wb_done;
          if ((got_rd | rd_done) && (got_wb | wb_done)) begin
            state <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (grp_more) begin
            oc_group <= oc_group + DIM_W'(1);
            state    <= S_ISSUE;
          end else begin
            oc_group <= '0;
            if (it_last) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
`ifdef PW_SCHED_PINGPONG_EN
              buf_sel   <= ~buf_sel;
              pf_issued <= 1'b0;
              pf_acked  <= 1'b0;
              state     <= (pf_acked || ack_now) ? S_ISSUE : S_LOAD;
`else
              state     <= S_LOAD;
              load_req  <= 1'b1;
              load_row  <= it_nrow;
              load_col  <= it_ncol;
              load_h    <= it_nh;
              load_w    <= it_nw;
              load_base <= base0_q;
`endif
            end
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pw_tile_sched.sv
// Bench for pw_tile_sched: vector table, hand sequences and random layers
// checked against a row-major tile/group model.
module tb_pw_tile_sched;

  localparam int ADDR_W = 32;
  localparam int DIM_W  = 16;
  localparam int OC_PAR = 8;
  localparam logic [ADDR_W-1:0] B0 = 32'h1000_0000;
  localparam logic [ADDR_W-1:0] B1 = 32'h2000_4000;
`ifdef PW_SCHED_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [DIM_W-1:0]  cfg_fm_h, cfg_fm_w, cfg_tile_h, cfg_tile_w;
  logic [DIM_W-1:0]  cfg_in_ch, cfg_out_ch;
  logic [ADDR_W-1:0] cfg_buf_base0, cfg_buf_base1;
  logic              load_req;
  logic [DIM_W-1:0]  load_row, load_col, load_h, load_w;
  logic [ADDR_W-1:0] load_base;
  logic              load_ack;
  logic              rd_start;
  logic [DIM_W-1:0]  rd_tile_h, rd_tile_w, rd_channels;
  logic [ADDR_W-1:0] rd_base_addr;
  logic              rd_done;
  logic [DIM_W-1:0]  oc_group;
  logic              wb_done;
  logic              busy;
  logic              done;

  pw_tile_sched #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W),
    .OC_PAR (OC_PAR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_fm_h      (cfg_fm_h),
    .cfg_fm_w      (cfg_fm_w),
    .cfg_tile_h    (cfg_tile_h),
    .cfg_tile_w    (cfg_tile_w),
    .cfg_in_ch     (cfg_in_ch),
    .cfg_out_ch    (cfg_out_ch),
    .cfg_buf_base0 (cfg_buf_base0),
    .cfg_buf_base1 (cfg_buf_base1),
    .load_req      (load_req),
    .load_row      (load_row),
    .load_col      (load_col),
    .load_h        (load_h),
    .load_w        (load_w),
    .load_base     (load_base),
    .load_ack      (load_ack),
    .rd_start      (rd_start),
    .rd_tile_h     (rd_tile_h),
    .rd_tile_w     (rd_tile_w),
    .rd_channels   (rd_channels),
    .rd_base_addr  (rd_base_addr),
    .rd_done       (rd_done),
    .oc_group      (oc_group),
    .wb_done       (wb_done),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int fm_h; int fm_w; int th; int tw; int ic; int oc;
    int rl; int wl; int ll; int exp_loads; int exp_rds;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int ld_lat = 0, rd_lat = 0, wb_lat = 0;
  int ld_cnt, rd_cnt, wb_cnt;
  bit rd_arm, wb_arm;
  int done_cnt, pf_cnt, overlap_cnt;
  logic [ADDR_W-1:0] pf_base;
  logic prev_lreq;
  logic [95:0] prev_lf;
  logic [95:0] obs_ld[$], obs_rd[$], exp_ld[$], exp_rd[$];

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Loader / reader / writeback responders plus event monitor.
  always @(negedge clk) begin
    logic [95:0] cur;
    load_ack = 1'b0;
    rd_done  = 1'b0;
    wb_done  = 1'b0;
    if (!rst_n) begin
      ld_cnt = 0; rd_arm = 0; wb_arm = 0; prev_lreq = 1'b0;
    end else begin
      cur = {load_row, load_col, load_h, load_w, load_base};
      if (load_req && prev_lreq) check("load_stable", cur, prev_lf);
      if (load_req && !prev_lreq && (rd_arm || wb_arm || rd_start)) begin
        pf_cnt++;
        pf_base = load_base;
      end
      prev_lreq = load_req;
      prev_lf   = cur;
      if (load_req) begin
        if (ld_cnt >= ld_lat) begin
          load_ack = 1'b1;
          ld_cnt   = 0;
          obs_ld.push_back(cur);
        end else ld_cnt++;
      end else ld_cnt = 0;
      if (done) done_cnt++;
      if (rd_start) begin
        if (rd_arm || wb_arm) overlap_cnt++;
        obs_rd.push_back({rd_tile_h, rd_tile_w, rd_channels,
                          rd_base_addr, oc_group});
        rd_cnt = rd_lat; wb_cnt = wb_lat; rd_arm = 1; wb_arm = 1;
      end else begin
        if (rd_arm) begin
          if (rd_cnt == 0) begin rd_done = 1'b1; rd_arm = 0; end
          else rd_cnt--;
        end
        if (wb_arm) begin
          if (wb_cnt == 0) begin wb_done = 1'b1; wb_arm = 0; end
          else wb_cnt--;
        end
      end
    end
  end

  // Reference: row-major tiles, each clipped at the map edge, each read
  // once per group of OC_PAR output channels.
  task automatic build_expected(input vec_t v);
    int ng, idx, h, w;
    logic [ADDR_W-1:0] b;
    exp_ld.delete();
    exp_rd.delete();
    if (v.fm_h == 0 || v.fm_w == 0 || v.th == 0 || v.tw == 0 ||
        v.ic == 0 || v.oc == 0) return;
    ng  = (v.oc + OC_PAR - 1) / OC_PAR;
    idx = 0;
    for (int r = 0; r < v.fm_h; r += v.th) begin
      for (int c = 0; c < v.fm_w; c += v.tw) begin
        h = (v.fm_h - r < v.th) ? v.fm_h - r : v.th;
        w = (v.fm_w - c < v.tw) ? v.fm_w - c : v.tw;
        b = (PP && (idx % 2 == 1)) ? B1 : B0;
        exp_ld.push_back({DIM_W'(r), DIM_W'(c), DIM_W'(h), DIM_W'(w), b});
        for (int g = 0; g < ng; g++)
          exp_rd.push_back({DIM_W'(h), DIM_W'(w), DIM_W'(v.ic), b,
                            DIM_W'(g)});
        idx++;
      end
    end
  endtask

  task automatic run_layer(input vec_t v);
    int el, er, npf;
    ld_lat = v.ll; rd_lat = v.rl; wb_lat = v.wl;
    build_expected(v);
    @(negedge clk);
    obs_ld.delete(); obs_rd.delete();
    done_cnt = 0; pf_cnt = 0; overlap_cnt = 0;
    cfg_fm_h   = DIM_W'(v.fm_h);
    cfg_fm_w   = DIM_W'(v.fm_w);
    cfg_tile_h = DIM_W'(v.th);
    cfg_tile_w = DIM_W'(v.tw);
    cfg_in_ch  = DIM_W'(v.ic);
    cfg_out_ch = DIM_W'(v.oc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 20000 && done_cnt == 0; i++) @(negedge clk);
    if (done_cnt == 0) $display("FAIL layer_timeout: got no done expected done");
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("busy_idle", busy, 0);
    el = (v.exp_loads >= 0) ? v.exp_loads : exp_ld.size();
    er = (v.exp_rds >= 0) ? v.exp_rds : exp_rd.size();
    check("n_loads", obs_ld.size(), el);
    check("n_rd_start", obs_rd.size(), er);
    for (int i = 0; i < exp_ld.size() && i < obs_ld.size(); i++)
      check("load_rec", obs_ld[i], exp_ld[i]);
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
      check("rd_rec", obs_rd[i], exp_rd[i]);
    check("rd_before_done", overlap_cnt, 0);
    npf = (PP && exp_ld.size() > 0) ? exp_ld.size() - 1 : 0;
    check("prefetch_cnt", pf_cnt, npf);
  endtask

  function automatic logic [255:0] all_outs();
    return {load_req, load_row, load_col, load_h, load_w, load_base,
            rd_start, rd_tile_h, rd_tile_w, rd_channels, rd_base_addr,
            oc_group, busy, done};
  endfunction

  vec_t tbl[9];
  int   exp_hw[6][2];

  initial begin
    vec_t v;
    logic [95:0] t;
    rst_n = 1'b0; start = 1'b0;
    cfg_fm_h = '0; cfg_fm_w = '0; cfg_tile_h = '0; cfg_tile_w = '0;
    cfg_in_ch = '0; cfg_out_ch = '0;
    cfg_buf_base0 = B0; cfg_buf_base1 = B1;
    load_ack = 1'b0; rd_done = 1'b0; wb_done = 1'b0;

    tbl[0] = '{8, 8, 4, 4, 16, 16, 2, 3, 1, 4, 8};
    tbl[1] = '{10, 6, 4, 4, 8, 8, 1, 1, 0, 6, 6};
    tbl[2] = '{4, 4, 4, 4, 8, 20, 2, 0, 2, 1, 3};
    tbl[3] = '{5, 5, 8, 8, 1, 1, 0, 0, 0, 1, 1};
    tbl[4] = '{8, 8, 4, 0, 4, 4, 1, 1, 1, 0, 0};
    tbl[5] = '{3, 7, 1, 3, 4, 9, 1, 2, 1, 9, 18};
    tbl[6] = '{2, 2, 2, 2, 4, 16, 6, 1, 1, 1, 2};
    tbl[7] = '{2, 2, 2, 2, 4, 16, 3, 3, 1, 1, 2};
    tbl[8] = '{4, 4, 2, 2, 4, 0, 1, 1, 1, 0, 0};
    exp_hw = '{'{4, 4}, '{4, 2}, '{4, 4}, '{4, 2}, '{2, 4}, '{2, 2}};

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", all_outs(), '0);

    for (int i = 0; i < 9; i++) run_layer(tbl[i]);

    // Edge-truncated tile sizes in row-major order.
    run_layer(tbl[1]);
    for (int i = 0; i < 6; i++) begin
      t = (i < obs_rd.size()) ? obs_rd[i] : '0;
      check("tile_hw", t[95:64], {DIM_W'(exp_hw[i][0]), DIM_W'(exp_hw[i][1])});
    end

    // out_ch 20 -> groups 0,1,2.
    run_layer(tbl[2]);
    for (int i = 0; i < 3; i++) begin
      t = (i < obs_rd.size()) ? obs_rd[i] : '0;
      check("oc_group_seq", t[15:0], i);
    end

    // Reset while a reader pass is outstanding.
    v = '{8, 8, 4, 4, 16, 16, 20, 20, 1, -1, -1};
    ld_lat = v.ll; rd_lat = v.rl; wb_lat = v.wl;
    obs_rd.delete();
    @(negedge clk);
    cfg_fm_h = 8; cfg_fm_w = 8; cfg_tile_h = 4; cfg_tile_w = 4;
    cfg_in_ch = 16; cfg_out_ch = 16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && obs_rd.size() == 0; i++) @(negedge clk);
    check("run_reached", obs_rd.size(), 1);
    repeat (3) @(negedge clk);
    check("busy_in_run", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_outputs", all_outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_layer(tbl[0]);

`ifdef PW_SCHED_PINGPONG_EN
    // Two tiles: second fill overlaps first RUN into base1.
    v = '{4, 8, 4, 4, 8, 8, 8, 8, 2, 2, 2};
    run_layer(v);
    check("pf_load_base", pf_base, B1);
    t = (obs_rd.size() > 1) ? obs_rd[1] : '0;
    check("tile1_rd_base", t[47:16], B1);
`endif

    for (int n = 0; n < 12; n++) begin
      v.fm_h = $urandom_range(1, 8);
      v.fm_w = $urandom_range(1, 8);
      v.th   = $urandom_range(1, 5);
      v.tw   = $urandom_range(1, 5);
      v.ic   = $urandom_range(1, 32);
      v.oc   = $urandom_range(1, 40);
      v.rl   = $urandom_range(0, 6);
      v.wl   = $urandom_range(0, 6);
      v.ll   = $urandom_range(0, 4);
      v.exp_loads = -1;
      v.exp_rds   = -1;
      run_layer(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
